bcd_to_binary_seq: RTL

- Iterative packed-BCD to unsigned-binary converter using reverse double-dabble (shift right, then subtract 3 from any digit ≥ 8).
- Inverse of the Binary-to-BCD path. Feeds keypad/display-entry values back into binary arithmetic.
- One conversion at a time, with a start/ready/done handshake. One shift/adjust step per clock.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/bcd_to_binary_seq_if.sv | 25 ++
 rtl/add_sub4.sv | 10 +
 rtl/bcd_digit_adjust.sv | 19 +
 rtl/bcd_to_binary_seq.sv | 125 ++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for the packed-BCD to binary converter.
// Optional feature macro: BCD_ERR_CHECK_EN (digit-range check at start).
package bcd_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [3:0] ADJ_THRESH = 4'd8;
    localparam logic [3:0] ADJ_VAL    = 4'd3;
    localparam logic [3:0] MAX_DIGIT  = 4'd9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int DEF_DIGITS = 4;
    localparam int DEF_BIN_W  = 14;

    // Counter must be able to hold the full iteration count BIN_W.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Start/ready/done handshake bundle for the BCD to binary converter.
// Optional feature macro: BCD_ERR_CHECK_EN (drives err when defined).
interface bcd_to_binary_seq_if
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
);
    logic                       start;
    logic [DIGITS*DIGIT_W-1:0]  bcd_in;
    logic                       ready;
    logic                       done;
    logic [BIN_W-1:0]           bin_out;
    logic                       err;

    modport master (
        output start, bcd_in,
        input  ready, done, bin_out, err
    );

    modport slave (
        input  start, bcd_in,
        output ready, done, bin_out, err
    );
endinterface

// File: rtl/add_sub4.sv
// Shared 4-bit adder/subtractor; sub=1 computes a - b in two's complement.
module add_sub4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       sub,
    output logic [3:0] result
);
    // Subtraction reuses the adder: invert b and inject the carry-in.
    assign result = a + (b ^ {4{sub}}) + {3'b000, sub};
endmodule

// File: rtl/bcd_digit_adjust.sv
// One digit of the reverse double-dabble correction: d >= 8 ? d - 3 : d.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_in,
    output logic [DIGIT_W-1:0] d_out
);
    logic [DIGIT_W-1:0] d_minus;

    add_sub4 u_sub (
        .a      (d_in),
        .b      (ADJ_VAL),
        .sub    (1'b1),
        .result (d_minus)
    );

    // A digit that reached 8+ after the shift carried a stray 5 from above; pull 3 back out.
    assign d_out = (d_in >= ADJ_THRESH) ? d_minus : d_in;
endmodule

// File: rtl/bcd_to_binary_seq.sv
// Iterative packed-BCD to unsigned binary converter (reverse double-dabble).
// Optional feature macro: BCD_ERR_CHECK_EN - when defined, digits > 9 are
// flagged at start and take a short error path with bin_out = 0.
module bcd_to_binary_seq
    import bcd_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int BIN_W  = DEF_BIN_W
)(
    input  logic clk,
    input  logic reset_n,
    bcd_to_binary_seq_if.slave bus
);
    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int W     = BCD_W + BIN_W;
    localparam int CNT_W = cnt_width(BIN_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

    logic [1:0]       state;
    logic [W-1:0]     work;
    logic [CNT_W-1:0] cnt;
    logic             done_q;
    logic [BIN_W-1:0] bin_q;
    logic             in_valid;
    logic             bad_digit;
    logic [W-1:0]     shifted;
    logic [W-1:0]     stepped;
`ifdef BCD_ERR_CHECK_EN
    logic             err_q;
`endif

    // One iteration: shift the whole register right, then correct every BCD digit.
    assign shifted = work >> 1;
    assign stepped[BIN_W-1:0] = shifted[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .d_in  (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
            .d_out (stepped[BIN_W + g*DIGIT_W +: DIGIT_W])
        );
    end

    // Flag any incoming digit outside 0..9.
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) begin
                bad_digit = 1'b1;
            end
        end
    end

    // Control FSM plus working register, iteration counter and result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            work     <= '0;
            cnt      <= '0;
            done_q   <= 1'b0;
            bin_q    <= '0;
            in_valid <= 1'b0;
`ifdef BCD_ERR_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        work     <= {bus.bcd_in, {BIN_W{1'b0}}};
                        cnt      <= '0;
                        in_valid <= !bad_digit;
`ifdef BCD_ERR_CHECK_EN
                        if (bad_digit) begin
                            err_q <= 1'b1;
                            bin_q <= '0;
                            state <= ST_DONE;
                        end else begin
                            err_q <= 1'b0;
                            state <= ST_SHIFT;
                        end
`else
                        state    <= ST_SHIFT;
`endif
                    end
                end
                ST_SHIFT: begin
                    work <= stepped;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == LAST_ITER) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
`ifdef BCD_ERR_CHECK_EN
                    bin_q  <= err_q ? '0 : work[BIN_W-1:0];
`else
                    bin_q  <= work[BIN_W-1:0];
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready   = (state == ST_IDLE);
    assign bus.done    = done_q;
    assign bus.bin_out = bin_q;
`ifdef BCD_ERR_CHECK_EN
    assign bus.err     = err_q;
`else
    assign bus.err     = 1'b0;
`endif

`ifndef SYNTHESIS
    // A valid input must have drained its BCD section completely by the last iteration.
    always_ff @(posedge clk) begin
        if (reset_n && state == ST_DONE && in_valid) begin
            assert (work[W-1:BIN_W] == '0);
        end
    end
`endif
endmodule
